// File: rtl/fetch_icache_assoc.sv
// Set-associative fetch instruction cache: registered one-cycle lookup, tag-compare snoop, internal refill sequencer.
// Build option FETCH_ICACHE_ASSOC_RR_PER_SET_EN: per-set round-robin victim pointer (default: one global pointer).
module fetch_icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 16,
    parameter int DATA_WIDTH = 36
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [31:0]                                q_addr,
    output logic                                       q_hit,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] q_way,
    output logic [DATA_WIDTH-1:0]                      q_data,
    input  logic                                       refill_req,
    input  logic [31:0]                                refill_addr,
    output logic                                       refill_ready,
    input  logic                                       refill_valid,
    input  logic [DATA_WIDTH-1:0]                      refill_data,
    output logic                                       refill_done,
    output logic                                       refill_aborted,
    input  logic                                       snoop_hit,
    input  logic [31:0]                                snoop_addr
);
    localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WW  = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int OFS = WW + 2;
    localparam int TAG = 32 - OFS - IDX;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
    state_t state_q, state_d;

    logic [SETS-1:0]                 valid_q [WAYS];
    logic [TAG-1:0]                  tag_q   [WAYS][SETS];
    logic [WAYS-1:0][DATA_WIDTH-1:0] rd_all;

    logic [TAG-1:0] l_tag, r_tag, s_tag, fill_tag_q;
    logic [IDX-1:0] l_idx, r_idx, s_idx, fill_idx_q;
    logic [WW-1:0]  l_word, cnt_q;
    logic [WB-1:0]  l_way, inv_way, cur_ptr, victim_d, victim_q, q_way_q;
    logic           l_hit, any_inv, used_ptr_q, abort_q, q_hit_q;
    logic           accept, beat, commit, snoop_fill_match, abort_now;
    logic           unused_bits;

    assign l_tag  = q_addr[31 -: TAG];
    assign l_idx  = q_addr[OFS +: IDX];
    assign l_word = q_addr[2 +: WW];
    assign r_tag  = refill_addr[31 -: TAG];
    assign r_idx  = refill_addr[OFS +: IDX];
    assign s_tag  = snoop_addr[31 -: TAG];
    assign s_idx  = snoop_addr[OFS +: IDX];
    assign unused_bits = ^{q_addr[1:0], refill_addr[OFS-1:0], snoop_addr[OFS-1:0]};

    // Descending scans leave the lowest qualifying way in the result.
    always_comb begin
        l_hit   = 1'b0;
        l_way   = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][l_idx] && tag_q[w][l_idx] == l_tag) begin
                l_hit = 1'b1;
                l_way = WB'(w);
            end
            if (!valid_q[w][r_idx]) begin
                any_inv = 1'b1;
                inv_way = WB'(w);
            end
        end
    end

    function automatic logic [WB-1:0] ptr_next(input logic [WB-1:0] p);
        return (int'(p) == WAYS - 1) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_ICACHE_ASSOC_RR_PER_SET_EN
    logic [WB-1:0] rr_q [SETS];
    assign cur_ptr = rr_q[r_idx];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (commit && used_ptr_q) begin
            rr_q[fill_idx_q] <= ptr_next(rr_q[fill_idx_q]);
        end
    end
`else
    logic [WB-1:0] rr_q;
    assign cur_ptr = rr_q;
    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else if (commit && used_ptr_q) rr_q <= ptr_next(rr_q);
    end
`endif

    assign victim_d         = any_inv ? inv_way : cur_ptr;
    assign snoop_fill_match = snoop_hit && s_tag == fill_tag_q && s_idx == fill_idx_q;
    assign abort_now        = abort_q || snoop_fill_match;

    // Handshake: refill_req is taken on a cycle where refill_ready is high and must be held until then;
    // in FILL every cycle with refill_valid high is one beat, there is no backpressure on beats.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        refill_ready   = 1'b0;
        refill_done    = 1'b0;
        refill_aborted = 1'b0;
        accept         = 1'b0;
        beat           = 1'b0;
        commit         = 1'b0;
        unique case (state_q)
            IDLE: begin
                refill_ready = 1'b1;
                if (refill_req) begin
                    accept  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (refill_valid) begin
                    beat = 1'b1;
                    if (&cnt_q) state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit         = 1'b1;
                refill_done    = 1'b1;
                refill_aborted = abort_now;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            cnt_q      <= '0;
            victim_q   <= '0;
            used_ptr_q <= 1'b0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            abort_q    <= 1'b0;
            q_hit_q    <= 1'b0;
            q_way_q    <= '0;
        end else begin
            q_hit_q <= l_hit;
            q_way_q <= l_way;
            if (accept) begin
                cnt_q      <= '0;
                victim_q   <= victim_d;
                used_ptr_q <= !any_inv;
                fill_tag_q <= r_tag;
                fill_idx_q <= r_idx;
                abort_q    <= 1'b0;
            end else begin
                if (beat) cnt_q <= cnt_q + 1'b1;
                if (state_q == FILL && snoop_fill_match) abort_q <= 1'b1;
            end
            // Snoop clear comes last so it wins over a same-edge commit.
            for (int w = 0; w < WAYS; w++) begin
                if (accept && victim_d == WB'(w)) valid_q[w][r_idx] <= 1'b0;
                if (commit && !abort_now && victim_q == WB'(w)) valid_q[w][fill_idx_q] <= 1'b1;
                if (snoop_hit && valid_q[w][s_idx] && tag_q[w][s_idx] == s_tag) valid_q[w][s_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) tag_q[victim_q][fill_idx_q] <= fill_tag_q;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [DATA_WIDTH-1:0] mem [SETS*LINE_WORDS];
        logic [DATA_WIDTH-1:0] rd;
        always_ff @(posedge clk) begin
            if (beat && victim_q == WB'(g)) mem[{fill_idx_q, cnt_q}] <= refill_data;
            rd <= mem[{l_idx, l_word}];
        end
        assign rd_all[g] = rd;
    end

    assign q_hit  = q_hit_q;
    assign q_way  = q_way_q;
    assign q_data = q_hit_q ? rd_all[q_way_q] : '0;
endmodule

// File: tb/tb_fetch_icache_assoc.sv
// Bench for fetch_icache_assoc: directed walk of the cache scenarios, randomized refills/snoops/lookups,
// every cycle compared against a line-level model of the cache contents.
module tb_fetch_icache_assoc;
  localparam int WAYS = 2;
  localparam int SETS = 128;
  localparam int LW   = 16;
  localparam int DW   = 36;
  localparam int OFS  = 6;
  localparam int IDX  = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   q_addr;
  logic          q_hit;
  logic [0:0]    q_way;
  logic [DW-1:0] q_data;
  logic          refill_req;
  logic [31:0]   refill_addr;
  logic          refill_ready;
  logic          refill_valid;
  logic [DW-1:0] refill_data;
  logic          refill_done;
  logic          refill_aborted;
  logic          snoop_hit;
  logic [31:0]   snoop_addr;

  fetch_icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .q_addr(q_addr), .q_hit(q_hit), .q_way(q_way), .q_data(q_data),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_ready(refill_ready),
    .refill_valid(refill_valid), .refill_data(refill_data), .refill_done(refill_done),
    .refill_aborted(refill_aborted), .snoop_hit(snoop_hit), .snoop_addr(snoop_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  bit rand_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // line-level model of the cache
  bit            m_valid [WAYS][SETS];
  int            m_tag   [WAYS][SETS];
  logic [DW-1:0] m_data  [WAYS][SETS][LW];
  int  m_ptr, m_way, m_beats, m_ftag, m_fidx;
  bit  m_busy, m_commit, m_abort, m_used_ptr;
  logic          exp_hit;
  logic [0:0]    exp_way;
  logic [DW-1:0] exp_data;

  function automatic int tag_of(input logic [31:0] a);
    return int'(a >> (OFS + IDX));
  endfunction
  function automatic int idx_of(input logic [31:0] a);
    return int'(a >> OFS) % SETS;
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'(a >> 2) % LW;
  endfunction
  function automatic bit snoop_on_fill();
    return m_busy && snoop_hit && tag_of(snoop_addr) == m_ftag && idx_of(snoop_addr) == m_fidx;
  endfunction

  task automatic m_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) m_valid[w][s] = 0;
    m_ptr = 0; m_busy = 0; m_commit = 0; m_abort = 0; m_used_ptr = 0;
    exp_hit = 0; exp_way = 0; exp_data = '0;
  endtask

  initial begin : model
    int li, lt, si, st, hw;
    bit h;
    m_reset();
    forever begin
      @(posedge clk);
      if (reset) m_reset();
      else begin
        lt = tag_of(q_addr); li = idx_of(q_addr);
        h = 0; hw = 0;
        for (int w = 0; w < WAYS; w++)
          if (!h && m_valid[w][li] && m_tag[w][li] == lt) begin h = 1; hw = w; end
        exp_hit  = h;
        exp_way  = 1'(hw);
        exp_data = h ? m_data[hw][li][word_of(q_addr)] : '0;
        if (m_commit) begin
          m_tag[m_way][m_fidx] = m_ftag;
          if (!(m_abort || snoop_on_fill())) m_valid[m_way][m_fidx] = 1;
          if (m_used_ptr) m_ptr = (m_ptr + 1) % WAYS;
          m_commit = 0; m_busy = 0;
        end else if (m_busy) begin
          if (snoop_on_fill()) m_abort = 1;
          if (refill_valid) begin
            m_data[m_way][m_fidx][m_beats] = refill_data;
            m_beats++;
            if (m_beats == LW) m_commit = 1;
          end
        end else if (refill_req) begin
          m_ftag = tag_of(refill_addr); m_fidx = idx_of(refill_addr);
          m_way = -1;
          for (int w = 0; w < WAYS; w++)
            if (m_way < 0 && !m_valid[w][m_fidx]) m_way = w;
          m_used_ptr = (m_way < 0);
          if (m_used_ptr) m_way = m_ptr;
          m_valid[m_way][m_fidx] = 0;
          m_busy = 1; m_beats = 0; m_abort = 0;
        end
        if (snoop_hit) begin
          st = tag_of(snoop_addr); si = idx_of(snoop_addr);
          for (int w = 0; w < WAYS; w++)
            if (m_valid[w][si] && m_tag[w][si] == st) m_valid[w][si] = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("q_hit", q_hit, exp_hit);
        if (exp_hit) chk("q_way", q_way, exp_way);
        chk("q_data", q_data, exp_data);
        chk("refill_ready", refill_ready, !m_busy);
        chk("refill_done", refill_done, m_commit);
        chk("refill_aborted", refill_aborted, m_commit && (m_abort || snoop_on_fill()));
      end
    end
  end

  // driver tasks
  function automatic logic [DW-1:0] rnd36();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  function automatic logic [31:0] pool();
    return (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 1) ? 65 : 3) << 6) |
           (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic step();
    @(posedge clk); #2;
    snoop_hit = 0;
  endtask

  task automatic rand_cycle();
    if (rand_mode) begin
      q_addr = pool();
      if ($urandom_range(0, 9) == 0) begin snoop_hit = 1; snoop_addr = pool(); end
    end
  endtask

  task automatic look(input logic [31:0] a, output logic h, output logic [0:0] w, output logic [DW-1:0] d);
    q_addr = a;
    step();
    @(negedge clk);
    h = q_hit; w = q_way; d = q_data;
    step();
  endtask

  // snoop_at: beat index during FILL, LW for the commit cycle, -1 for none
  task automatic refill(input logic [31:0] a, input int gap_pct, input int snoop_at, input logic [31:0] s_addr,
                        input bit idx_data, output int cycles, output bit done, output bit aborted);
    int beat;
    bit snooped;
    refill_req = 1; refill_addr = a; cycles = 1;
    rand_cycle();
    step();
    refill_req = 0; refill_addr = $urandom;
    beat = 0; snooped = 0;
    while (beat < LW) begin
      refill_valid = ($urandom_range(0, 99) >= gap_pct);
      refill_data  = idx_data ? DW'(beat) : rnd36();
      rand_cycle();
      if (!snooped && snoop_at == beat) begin snoop_hit = 1; snoop_addr = s_addr; snooped = 1; end
      step();
      if (refill_valid) beat++;
      cycles++;
    end
    refill_valid = 0;
    rand_cycle();
    if (snoop_at == LW) begin snoop_hit = 1; snoop_addr = s_addr; end
    @(negedge clk);
    done = refill_done; aborted = refill_aborted; cycles++;
    step();
  endtask

  initial begin : driver
    logic h;
    logic [0:0] w;
    logic [DW-1:0] d;
    int cyc;
    bit dn, ab, seen_done;

    reset = 1; q_addr = 0; refill_req = 0; refill_addr = 0; refill_valid = 0;
    refill_data = '0; snoop_hit = 0; snoop_addr = 0;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_q_hit", q_hit, 0);
    chk("rst_q_way", q_way, 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_ready", refill_ready, 1);
    chk("rst_done", refill_done, 0);
    chk("rst_aborted", refill_aborted, 0);
    chk_en = 1;
    step();
    reset = 0;

    look(32'h0000_1040, h, w, d);
    chk("cold_hit", h, 0);
    chk("cold_data", d, 0);
    refill(32'h0000_1040, 0, -1, 0, 1, cyc, dn, ab);
    chk("r1_cycles", cyc, 18);
    chk("r1_done", dn, 1);
    chk("r1_aborted", ab, 0);
    look(32'h0000_1048, h, w, d);
    chk("w2_hit", h, 1);
    chk("w2_way", w, 0);
    chk("w2_data", d, 2);

    refill(32'h0000_3040, 20, -1, 0, 0, cyc, dn, ab);
    look(32'h0000_1040, h, w, d);
    chk("two_a_hit", h, 1);
    chk("two_a_way", w, 0);
    look(32'h0000_3040, h, w, d);
    chk("two_b_hit", h, 1);
    chk("two_b_way", w, 1);

    refill(32'h0000_5040, 20, -1, 0, 0, cyc, dn, ab);
    look(32'h0000_1040, h, w, d);
    chk("evict_old_hit", h, 0);
    look(32'h0000_3040, h, w, d);
    chk("evict_keep_way", {h, w}, 2'b11);
    look(32'h0000_5040, h, w, d);
    chk("evict_new_way", {h, w}, 2'b10);

    snoop_hit = 1; snoop_addr = 32'h0000_3044;
    step();
    look(32'h0000_3040, h, w, d);
    chk("snoop_drop", h, 0);
    look(32'h0000_5040, h, w, d);
    chk("snoop_keep", h, 1);
    snoop_hit = 1; snoop_addr = 32'h0000_7040;
    step();
    look(32'h0000_5040, h, w, d);
    chk("snoop_miss_keep", h, 1);

    refill(32'h0000_9040, 10, 5, 32'h0000_9040, 0, cyc, dn, ab);
    chk("fill_snoop_done", dn, 1);
    chk("fill_snoop_aborted", ab, 1);
    look(32'h0000_9040, h, w, d);
    chk("fill_snoop_miss", h, 0);
    refill(32'h0000_B040, 10, LW, 32'h0000_B048, 0, cyc, dn, ab);
    chk("commit_snoop_done", dn, 1);
    chk("commit_snoop_aborted", ab, 1);
    look(32'h0000_B040, h, w, d);
    chk("commit_snoop_miss", h, 0);
    refill(32'h0000_9040, 0, -1, 0, 0, cyc, dn, ab);
    chk("clean_aborted", ab, 0);
    look(32'h0000_9040, h, w, d);
    chk("clean_way", {h, w}, 2'b11);

    rand_mode = 1;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin rand_cycle(); step(); end
      refill(pool(), $urandom_range(0, 40), -1, 0, 0, cyc, dn, ab);
    end
    rand_mode = 0;

    refill(32'h0000_1040, 0, -1, 0, 0, cyc, dn, ab);
    look(32'h0000_1040, h, w, d);
    chk("pre_rst_hit", h, 1);
    refill_req = 1; refill_addr = 32'h0000_3040;
    step();
    refill_req = 0;
    for (int b = 0; b < 7; b++) begin refill_valid = 1; refill_data = rnd36(); step(); end
    refill_valid = 1; refill_data = rnd36(); reset = 1;
    step();
    reset = 0; refill_valid = 0;
    @(negedge clk);
    chk("mid_rst_ready", refill_ready, 1);
    seen_done = refill_done;
    for (int i = 0; i < 20; i++) begin step(); @(negedge clk); seen_done |= refill_done; end
    step();
    chk("mid_rst_no_done", seen_done, 0);
    look(32'h0000_1040, h, w, d);
    chk("mid_rst_miss_a", h, 0);
    look(32'h0000_3040, h, w, d);
    chk("mid_rst_miss_b", h, 0);
    look(32'h0000_5040, h, w, d);
    chk("mid_rst_miss_c", {h, d}, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
